// File: rtl/vx_tensor_uop_seq_if.sv
// rtl/vx_tensor_uop_seq_if.sv - macro-op in, uop out and commit signals of the tensor uop sequencer
// The master side drives macro-ops, accepts uops and reports commits; the sequencer is the slave.
`ifndef UUID_WIDTH
`define UUID_WIDTH 8
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 6
`endif

interface vx_tensor_uop_seq_if #(
  parameter int CNTW = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [`UUID_WIDTH-1:0]   in_uuid;
  logic [`NW_WIDTH-1:0]     in_wid;
  logic [`NUM_THREADS-1:0]  in_tmask;
  logic [`XLEN-1:0]         in_PC;
  logic [`NR_BITS-1:0]      in_rd;
  logic [`NR_BITS-1:0]      in_rs1;
  logic [`NR_BITS-1:0]      in_rs2;
  logic [`NR_BITS-1:0]      in_rs3;

  logic                     out_valid;
  logic                     out_ready;
  logic [`UUID_WIDTH-1:0]   out_uuid;
  logic [`NW_WIDTH-1:0]     out_wid;
  logic [`NUM_THREADS-1:0]  out_tmask;
  logic [`XLEN-1:0]         out_PC;
  logic [1:0]               out_step;
  logic                     out_last_in_pair;
  logic                     out_wb;
  logic [`NR_BITS-1:0]      out_rd;
  logic [`NR_BITS-1:0]      out_rs1;
  logic [`NR_BITS-1:0]      out_rs2;
  logic [`NR_BITS-1:0]      out_rs3;

  logic                     cmt_fire;
  logic [CNTW-1:0]          outstanding;

  modport master (
    output in_valid, in_uuid, in_wid, in_tmask, in_PC, in_rd, in_rs1, in_rs2, in_rs3,
    output out_ready, cmt_fire,
    input  in_ready, out_valid, out_uuid, out_wid, out_tmask, out_PC, out_step,
    input  out_last_in_pair, out_wb, out_rd, out_rs1, out_rs2, out_rs3, outstanding
  );

  modport slave (
    input  in_valid, in_uuid, in_wid, in_tmask, in_PC, in_rd, in_rs1, in_rs2, in_rs3,
    input  out_ready, cmt_fire,
    output in_ready, out_valid, out_uuid, out_wid, out_tmask, out_PC, out_step,
    output out_last_in_pair, out_wb, out_rd, out_rs1, out_rs2, out_rs3, outstanding
  );
endinterface

// File: rtl/vx_tensor_uop_seq.sv
// rtl/vx_tensor_uop_seq.sv - expands one HMMA macro-op into 8 tensor-core uops
// Pairs are issued atomically and throttled by a credit count of uncommitted uops.
`ifndef UUID_WIDTH
`define UUID_WIDTH 8
`endif
`ifndef NW_WIDTH
`define NW_WIDTH 2
`endif
`ifndef NUM_THREADS
`define NUM_THREADS 4
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 6
`endif

module vx_tensor_uop_seq #(
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNTW = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic                clk,
  input logic                reset,
  vx_tensor_uop_seq_if.slave bus
);
  typedef enum logic {IDLE, ISSUE} state_t;
  typedef logic [`NR_BITS-1:0] reg_t;

  localparam logic [CNTW-1:0] PAIR_LIMIT = CNTW'(MAX_OUTSTANDING - 2);

  state_t                  state;
  state_t                  state_nxt;
  logic [2:0]              cnt;
  logic [`UUID_WIDTH-1:0]  uuid_q;
  logic [`NW_WIDTH-1:0]    wid_q;
  logic [`NUM_THREADS-1:0] tmask_q;
  logic [`XLEN-1:0]        pc_q;
  reg_t                    rd_q;
  reg_t                    rs1_q;
  reg_t                    rs2_q;
  reg_t                    rs3_q;
  logic [CNTW-1:0]         outstanding_q;

  logic       in_fire;
  logic       out_fire;
  logic       cmt_take;
  logic       credit_ok;
  logic [1:0] step;
  logic       p;

  assign step      = cnt[2:1];
  assign p         = cnt[0];
  // The second uop of a pair rides on the credit reserved by the first.
  assign credit_ok = p || (outstanding_q <= PAIR_LIMIT);
  assign in_fire   = bus.in_valid && bus.in_ready;
  assign out_fire  = bus.out_valid && bus.out_ready;
  assign cmt_take  = bus.cmt_fire && (outstanding_q != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_fire) state_nxt = ISSUE;
      ISSUE:   if (out_fire && (cnt == 3'd7)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE:    bus.in_ready  = reset;
      ISSUE:   bus.out_valid = credit_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      uuid_q  <= '0;
      wid_q   <= '0;
      tmask_q <= '0;
      pc_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rs3_q   <= '0;
    end else if (in_fire) begin
      cnt     <= '0;
      uuid_q  <= bus.in_uuid;
      wid_q   <= bus.in_wid;
      tmask_q <= bus.in_tmask;
      pc_q    <= bus.in_PC;
      rd_q    <= bus.in_rd;
      rs1_q   <= bus.in_rs1;
      rs2_q   <= bus.in_rs2;
      rs3_q   <= bus.in_rs3;
    end else if (out_fire) begin
      cnt <= cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding_q <= '0;
    end else if (out_fire && !cmt_take) begin
      outstanding_q <= outstanding_q + 1'b1;
    end else if (!out_fire && cmt_take) begin
      outstanding_q <= outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(bus.cmt_fire && (outstanding_q == '0)))
        else $warning("cmt_fire with no outstanding uops");
    end
  end

  assign bus.outstanding      = outstanding_q;
  assign bus.out_uuid         = uuid_q;
  assign bus.out_wid          = wid_q;
  assign bus.out_tmask        = tmask_q;
  assign bus.out_PC           = pc_q;
  assign bus.out_step         = step;
  assign bus.out_last_in_pair = p;
  assign bus.out_wb           = bus.out_valid;
  // A tile walks rows with step[0] and columns with step[1]; steps 1-3 accumulate into D.
  assign bus.out_rs1 = rs1_q + {{(`NR_BITS-2){1'b0}}, step[0], p};
  assign bus.out_rs2 = rs2_q + {{(`NR_BITS-2){1'b0}}, step[1], p};
  assign bus.out_rd  = rd_q + reg_t'(p);
  assign bus.out_rs3 = ((step == 2'd0) ? rs3_q : rd_q) + reg_t'(p);
endmodule
